prog_loader: RTL and testbench
==============================

# prog_loader

Byte-stream program loader that fills the core's program memory through its external write port (W, ADDR, DATA_WR) and holds the core in reset while loading. It sits between a host byte source (UART RX or debug bridge) and the processor top level. It validates a framed image (sync, length, payload, checksum), then releases the core to run.

## Interface
Parameters:
- DATA_SIZE, 6, instruction width written to program memory
- ADDR_SIZE, 5, program memory address width; max image 2^ADDR_SIZE words
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT, 1023, max idle cycles between bytes inside a frame
- BOOT_HOLD, 1, 1: core_rstn held low out of reset until a good image loads; 0: core_rstn high out of reset

Ports:
- clk  in  1  clock
- rstn  in  1  reset rstn, asynchronous, active-low; clock clk
- in_data  in  8  host byte
- in_valid  in  1  host byte valid
- in_ready  out  1  loader accepts byte (transfer = in_valid & in_ready)
- W  out  1  program memory write strobe, one cycle per word
- ADDR  out  ADDR_SIZE  program memory write address
- DATA_WR  out  DATA_SIZE  program memory write data
- core_rstn  out  1  active-low reset to the processor core
- busy  out  1  frame in progress
- done  out  1  last frame loaded and checksum good
- err_code  out  2  0 none, 1 bad length, 2 checksum mismatch, 3 timeout

## Operation
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- in_ready = 1 in every state; loader never back-pressures.
- IDLE/DONE/ERR: accepted byte == SYNC_BYTE -> LEN; core_rstn <= 0, done <= 0, err_code <= 0, busy <= 1. Other bytes are dropped, state unchanged.
- LEN: accepted byte N; N == 0 or N > 2^ADDR_SIZE -> ERR, code 1. Else store N, sum <= N, idx <= 0 -> DATA.
- DATA: each accepted byte b: write word idx with b[DATA_SIZE-1:0]; upper bits are ignored for the write but included in the sum; sum <= sum + b (mod 256); idx++. After the Nth byte -> CSUM.
- CSUM: accepted byte c; c == sum -> DONE, core_rstn <= 1, done <= 1, busy <= 0. Else -> ERR, code 2.
- A SYNC_BYTE value inside LEN/DATA/CSUM is data, not a restart.
- Timeout: idle counter resets on every accepted byte and on entry to LEN. In LEN/DATA/CSUM, counter reaching TIMEOUT -> ERR, code 3.
- ERR: busy <= 0, core_rstn stays 0, done 0; words already written remain in memory.
- Reset values: state IDLE, W 0, ADDR 0, DATA_WR 0, busy 0, done 0, err_code 0, core_rstn = !BOOT_HOLD.
- Reset mid-frame aborts immediately; any partial image is abandoned and core_rstn takes its reset value.

## Timing
- Write latency: byte k accepted at edge t -> W = 1, ADDR = k, DATA_WR = b[5:0] for exactly the cycle after t. Back-to-back bytes give back-to-back W pulses with consecutive ADDR.
- W is never high outside DATA-driven pulses; ADDR/DATA_WR hold their last value when W = 0.
- core_rstn rises and done asserts on the edge after the checksum byte is accepted. The final W pulse completes before that edge.
- err_code/ERR are registered and visible the cycle after the offending byte, or the cycle the counter hits TIMEOUT.
- A sync byte accepted while in DONE drops core_rstn on the next edge and restarts loading.

## Structure
- Package prog_loader_pkg: loader_state_t enum (IDLE, LEN, DATA, CSUM, DONE, ERR), err code localparams (ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT), default SYNC_BYTE.
- Sub-module byte_timer: loadable idle counter with clear, enable, and an expired flag, parameterised by TIMEOUT.
- Main FSM, sum/idx registers and the write pipeline register live in prog_loader.

## Test plan
- Frame A5, 03, 01, 02, 3F, CSUM 45 -> W pulses at ADDR 0/1/2 with 01/02/3F; done = 1, core_rstn = 1, err_code = 0.
- Length 00 and length 21 (with ADDR_SIZE 5) -> ERR, err_code = 1, no W pulses, core_rstn = 0.
- Frame A5, 02, C5, 01, CSUM 00 (correct C8) -> ADDR 0 written 05, ADDR 1 written 01, err_code = 2, core_rstn = 0.
- A5, 04, then two bytes, then silence for TIMEOUT cycles -> err_code = 3 on that cycle, busy = 0.
- Good load, then in DONE send A5 + 32-word frame with in_valid held high -> core_rstn drops next edge; 32 consecutive W pulses at ADDR 0..31; done again.
- Assert rstn mid-DATA -> all outputs at reset values next cycle (core_rstn = 0 with BOOT_HOLD = 1); garbage bytes before A5 are ignored.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the framed program loader.
// No logic here; latency and backpressure are described by the modules that use it.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/prog_loader_if.sv
// Host byte stream in, program memory write port out.
// Latency and backpressure are set by the loader; the master side is the host/bench.
interface prog_loader_if #(
  parameter int DATA_SIZE = 6,
  parameter int ADDR_SIZE = 5
);

  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 W;
  logic [ADDR_SIZE-1:0] ADDR;
  logic [DATA_SIZE-1:0] DATA_WR;

  modport master (
    output in_data, in_valid,
    input  in_ready, W, ADDR, DATA_WR
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, W, ADDR, DATA_WR
  );

endinterface

// File: rtl/prog_loader_byte_timer.sv
// Idle counter between accepted bytes; expired fires on the edge the count would reach TIMEOUT.
// Zero latency on expired (combinational from the count); no backpressure.
module byte_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int            CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // An accepted byte on the same edge always wins over expiry.
  assign expired = en && !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed image loader (sync, len, payload, checksum) writing program memory and gating core reset.
// Write strobe one cycle after each payload byte; in_ready is always 1, the loader never stalls.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         DATA_SIZE = 6,
  parameter int         ADDR_SIZE = 5,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT   = 1023,
  parameter bit         BOOT_HOLD = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  prog_loader_if.slave        bus,
  output logic                core_rstn,
  output logic                busy,
  output logic                done,
  output logic [1:0]          err_code
);

  loader_state_t        state_q, state_d;
  logic [7:0]           len_q, len_d;
  logic [7:0]           sum_q, sum_d;
  logic [ADDR_SIZE-1:0] idx_q, idx_d;
  logic                 w_q, w_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 core_rstn_q, core_rstn_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [1:0]           err_q, err_d;

  logic accept;
  logic in_frame;
  logic expired;

  assign accept   = bus.in_valid;
  assign in_frame = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);

  byte_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (accept || !in_frame),
    .en      (in_frame),
    .expired (expired)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    w_d         = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    core_rstn_d = core_rstn_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (accept && bus.in_data == SYNC_BYTE) begin
          state_d     = LEN;
          core_rstn_d = 1'b0;
          done_d      = 1'b0;
          err_d       = ERR_NONE;
          busy_d      = 1'b1;
        end
      end
      LEN: begin
        if (accept) begin
          if (bus.in_data == 8'd0 || int'(bus.in_data) > (1 << ADDR_SIZE)) begin
            state_d = ERR;
            err_d   = ERR_LEN;
            busy_d  = 1'b0;
          end else begin
            len_d   = bus.in_data;
            sum_d   = bus.in_data;
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          // Only the low bits reach memory, but the full byte is checksummed.
          w_d    = 1'b1;
          addr_d = idx_q;
          data_d = bus.in_data[DATA_SIZE-1:0];
          sum_d  = sum_q + bus.in_data;
          idx_d  = idx_q + ADDR_SIZE'(1);
          if (int'(idx_q) + 1 == int'(len_q)) begin
            state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (accept) begin
          busy_d = 1'b0;
          if (bus.in_data == sum_q) begin
            state_d     = DONE;
            core_rstn_d = 1'b1;
            done_d      = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = ERR_CSUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (in_frame && expired) begin
      state_d = ERR;
      err_d   = ERR_TIMEOUT;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      len_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      w_q         <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      core_rstn_q <= !BOOT_HOLD;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      w_q         <= w_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      core_rstn_q <= core_rstn_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready = 1'b1;
  assign bus.W        = w_q;
  assign bus.ADDR     = addr_q;
  assign bus.DATA_WR  = data_q;
  assign core_rstn    = core_rstn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_code     = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized frame-level bench for prog_loader against a positional frame model.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int DS   = 6;
  localparam int AS   = 5;
  localparam int TO   = 1023;
  localparam int MAXW = 1 << AS;

  logic       clk = 1'b0;
  logic       rstn;
  logic       core_rstn;
  logic       busy;
  logic       done;
  logic [1:0] err_code;

  prog_loader_if #(.DATA_SIZE(DS), .ADDR_SIZE(AS)) bus ();

  prog_loader #(
    .DATA_SIZE (DS),
    .ADDR_SIZE (AS),
    .SYNC_BYTE (8'hA5),
    .TIMEOUT   (TO),
    .BOOT_HOLD (1'b1)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .core_rstn (core_rstn),
    .busy      (busy),
    .done      (done),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_fail    = 0;
  int exp_w_cnt = 0;
  int got_w_cnt = 0;

  logic [DS-1:0] mem_exp [MAXW];
  logic [DS-1:0] mem_got [MAXW];
  logic [7:0]    payload [$];

  // Expected status outside a frame, updated at the end of every frame.
  logic       exp_done;
  logic       exp_core;
  logic [1:0] exp_err;

  always @(negedge clk) begin
    if (bus.W === 1'b1) begin
      got_w_cnt++;
      mem_got[bus.ADDR] = bus.DATA_WR;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input logic b, input logic c, input logic d, input logic [1:0] e);
    check_eq({tag, "_busy"}, busy, b);
    check_eq({tag, "_core_rstn"}, core_rstn, c);
    check_eq({tag, "_done"}, done, d);
    check_eq({tag, "_err"}, err_code, e);
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit is_data, input int addr);
    for (int i = 0; i < gap; i++) begin
      bus.in_valid = 1'b0;
      tick();
      check_eq("w_idle", bus.W, 0);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    check_eq("w_strobe", bus.W, is_data);
    if (is_data) begin
      check_eq("w_addr", bus.ADDR, addr);
      check_eq("w_data", bus.DATA_WR, b[DS-1:0]);
      mem_exp[addr] = b[DS-1:0];
      exp_w_cnt++;
    end
  endtask

  // csum_arg < 0 sends the correct checksum; otherwise that exact byte is sent.
  task automatic run_frame(input logic [7:0] len, input int csum_arg, input int gmax);
    logic [7:0] sum;
    logic [7:0] c;
    send(8'hA5, $urandom_range(0, gmax), 1'b0, 0);
    check_status("sync", 1'b1, 1'b0, 1'b0, ERR_NONE);
    send(len, $urandom_range(0, gmax), 1'b0, 0);
    if (len == 8'd0 || int'(len) > MAXW) begin
      exp_done = 1'b0; exp_core = 1'b0; exp_err = ERR_LEN;
      check_status("badlen", 1'b0, 1'b0, 1'b0, ERR_LEN);
      return;
    end
    check_status("len", 1'b1, 1'b0, 1'b0, ERR_NONE);
    sum = len;
    for (int i = 0; i < int'(len); i++) begin
      send(payload[i], $urandom_range(0, gmax), 1'b1, i);
      sum = sum + payload[i];
    end
    c = (csum_arg < 0) ? sum : 8'(csum_arg);
    send(c, $urandom_range(0, gmax), 1'b0, 0);
    if (c == sum) begin
      exp_done = 1'b1; exp_core = 1'b1; exp_err = ERR_NONE;
    end else begin
      exp_done = 1'b0; exp_core = 1'b0; exp_err = ERR_CSUM;
    end
    check_status("csum", 1'b0, exp_core, exp_done, exp_err);
  endtask

  task automatic fill_payload(input int n);
    payload.delete();
    for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    foreach (mem_exp[i]) begin
      mem_exp[i] = '0;
      mem_got[i] = '0;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    rstn = 1'b0;
    tick();
    tick();
    check_eq("rst_w", bus.W, 0);
    check_eq("rst_addr", bus.ADDR, 0);
    check_eq("rst_data", bus.DATA_WR, 0);
    check_eq("rst_ready", bus.in_ready, 1);
    check_status("rst", 1'b0, 1'b0, 1'b0, ERR_NONE);
    rstn = 1'b1;
    tick();

    // Reference frame with hand-computed checksum.
    payload = '{8'h01, 8'h02, 8'h3F};
    run_frame(8'h03, 'h45, 0);
    check_eq("ref_done", done, 1);

    // Length bounds.
    run_frame(8'h00, -1, 1);
    run_frame(8'h21, -1, 1);

    // Upper payload bits reach the sum but not memory; checksum should be C8.
    payload = '{8'hC5, 8'h01};
    run_frame(8'h02, 'h00, 1);
    check_eq("csum_mem0", mem_got[0], 6'h05);
    check_eq("csum_mem1", mem_got[1], 6'h01);

    // Sync value inside the payload is ordinary data.
    payload = '{8'hA5, 8'hA5};
    run_frame(8'h02, -1, 2);

    // Good load, then a full-size back-to-back reload from DONE.
    fill_payload(4);
    run_frame(8'h04, -1, 1);
    fill_payload(MAXW);
    run_frame(8'(MAXW), -1, 0);

    // Inter-byte timeout: error lands exactly TO idle edges after the last byte.
    fill_payload(4);
    send(8'hA5, 0, 1'b0, 0);
    send(8'h04, 0, 1'b0, 0);
    send(payload[0], 0, 1'b1, 0);
    send(payload[1], 1, 1'b1, 1);
    repeat (TO - 1) tick();
    check_status("to_pre", 1'b1, 1'b0, 1'b0, ERR_NONE);
    tick();
    check_status("to_hit", 1'b0, 1'b0, 1'b0, ERR_TIMEOUT);

    // Reset mid-payload, then garbage before a fresh frame.
    fill_payload(8);
    send(8'hA5, 0, 1'b0, 0);
    send(8'h08, 0, 1'b0, 0);
    for (int i = 0; i < 3; i++) send(payload[i], 0, 1'b1, i);
    rstn = 1'b0;
    #1;
    check_eq("arst_w", bus.W, 0);
    check_eq("arst_addr", bus.ADDR, 0);
    check_eq("arst_data", bus.DATA_WR, 0);
    check_status("arst", 1'b0, 1'b0, 1'b0, ERR_NONE);
    tick();
    rstn = 1'b1;
    exp_done = 1'b0; exp_core = 1'b0; exp_err = ERR_NONE;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] g;
      g = 8'($urandom);
      if (g == 8'hA5) g = 8'h5A;
      send(g, $urandom_range(0, 2), 1'b0, 0);
      check_status("garbage", 1'b0, exp_core, exp_done, exp_err);
    end

    // Random frames; between frames, junk bytes must not disturb status.
    for (int f = 0; f < 25; f++) begin
      int         r;
      logic [7:0] len;
      int         cs;
      r = $urandom_range(0, 9);
      if (r == 0) len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXW + 1, 255));
      else        len = 8'($urandom_range(1, MAXW));
      fill_payload(int'(len));
      cs = ($urandom_range(0, 3) == 0) ? int'(8'($urandom)) : -1;
      if ($urandom_range(0, 2) == 0) begin
        logic [7:0] g;
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        send(g, $urandom_range(0, 3), 1'b0, 0);
        check_status("junk", 1'b0, exp_core, exp_done, exp_err);
      end
      run_frame(len, cs, 3);
    end

    tick();
    tick();
    check_eq("w_count", got_w_cnt, exp_w_cnt);
    for (int i = 0; i < MAXW; i++) check_eq("mem", mem_got[i], mem_exp[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
